nn_sequencer: RTL and testbench
===============================

NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 SHALL have parameter N_PIX, default 784, meaning input pixels per image (28x28).
REQ-002 SHALL have parameter N_HID, default 56, meaning hidden neurons and the MUL/ADD lanes per step.
REQ-003 SHALL have parameter AW, default 10, meaning width of the pixel and weight-row addresses.
REQ-004 SHALL be clocked by one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: request one inference, sampled in IDLE only.
REQ-008 SHALL have port pix_addr, output, AW bits: pixel memory read address.
REQ-009 SHALL have port wt_addr, output, AW bits: weight ROM row address (one 896-bit row per step).
REQ-010 SHALL have port l1_sel, output, 6 bits: hidden-neuron index selecting l1_value.
REQ-011 SHALL have ports mul_0 and add_0, output, 1 bit each: layer-1 multiply/accumulate strobes.
REQ-012 SHALL have ports mul_1 and add_1, output, 1 bit each: layer-2 multiply/accumulate strobes.
REQ-013 SHALL have port l1_en, output, 1 bit: load next_l1_reg into l1_reg.
REQ-014 SHALL have port out_en, output, 1 bit: load next_output_reg into output_reg.
REQ-015 SHALL have port clr, output, 1 bit: zero l1_reg and output_reg.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, CLEAR, L1, L2, DRAIN, DONE.
REQ-019 SHALL move IDLE->CLEAR on start=1; CLEAR->L1 after 1 cycle with clr=1 for that cycle only.
REQ-020 SHALL, in L1, issue pix_addr=wt_addr=k for k=0..N_PIX-1, one per cycle, then enter L2.
REQ-021 SHALL, in L2, issue wt_addr=N_PIX+j and l1_sel=j for j=0..N_HID-1, one per cycle, then enter DRAIN.
REQ-022 SHALL move DRAIN->DONE after 1 cycle and DONE->IDLE after 1 cycle, with done=1 only in DONE.
REQ-023 SHALL account for the 1-cycle read latency of pixel memory and weight ROM: mul_0=add_0=l1_en asserted exactly one cycle after each L1 issue, and mul_1=add_1=out_en one cycle after each L2 issue.
REQ-024 SHALL delay l1_sel by one cycle alongside its strobe, so the strobe and the selected index arrive in the same cycle.
REQ-025 SHALL never assert the layer-1 and layer-2 strobe sets in the same cycle; the last L1 strobe coincides with the first L2 issue.
REQ-026 SHALL produce exactly N_PIX L1 strobes and N_HID L2 strobes per run; with defaults, start at cycle 0 gives clr at 1, L1 strobes at 3..786, L2 strobes at 787..842, done at 843.
REQ-027 SHALL ignore start outside IDLE; start held high through DONE begins a new run on the cycle after return to IDLE.
REQ-028 SHALL hold all addresses at 0 and all strobes low while in IDLE.
REQ-029 SHALL use AW-bit address arithmetic with a terminal-count compare, never relying on wrap-around.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, enter IDLE and drive every output and pipeline register to 0.
REQ-031 SHALL, on reset mid-run, abandon the run without a done pulse, and the next start SHALL begin with CLEAR.

Structure
REQ-032 SHALL take N_PIX, N_HID, the L2 weight base (N_PIX), and the state encoding from shared package nn_ctrl_pkg.
REQ-033 SHALL instantiate one sub-module, nn_step_counter: a clearable, enabled counter with a terminal-count flag, used for both the k and j indices.

Verification
REQ-034 SHALL check that rst_n=0 for 2 cycles gives busy=done=clr=0, all strobes 0, and pix_addr=wt_addr=0.
REQ-035 SHALL check that one start pulse gives 784 mul_0 pulses with wt_addr sequence 0..783, then 56 mul_1 pulses with wt_addr 784..839, and done at cycle 843.
REQ-036 SHALL check that start pulses during L1 (e.g. at cycle 100) are ignored: exactly one done, and strobe counts stay unchanged.
REQ-037 SHALL check that rst_n=0 at cycle 400 drops busy the next cycle with no done; a later start reruns the full 843-cycle sequence.
REQ-038 SHALL check that start tied high gives back-to-back runs, each done followed 2 cycles later by clr.
REQ-039 SHALL check that a scoreboard running MUL_ADD_Bank with random weights and pixels ends with an output_reg equal to the reference matrix-product model.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared constants and state encoding for the two-layer NN inference sequencer.
package nn_ctrl_pkg;

  localparam int NN_N_PIX = 784;
  localparam int NN_N_HID = 56;
  localparam int NN_AW    = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_L1,
    ST_L2,
    ST_DRAIN,
    ST_DONE
  } nn_state_t;

  // Layer-2 weight rows are stored directly after the N_PIX layer-1 rows.
  function automatic int l2_base(input int n_pix);
    return n_pix;
  endfunction

  localparam int NN_L2_BASE = l2_base(NN_N_PIX);

endpackage

// File: rtl/nn_step_counter.sv
// Clearable, enabled step counter; wraps to zero when it advances past 'last'.
module nn_step_counter #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic [AW-1:0] last,
  output logic [AW-1:0] count,
  output logic          tc
);

  assign tc = (count == last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/nn_sequencer.sv
// Control sequencer for a pixel->hidden->output network: walks layer-1 and
// layer-2 weight rows and emits MUL/ADD strobes aligned to 1-cycle memory latency.
module nn_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int N_PIX = NN_N_PIX,
  parameter int N_HID = NN_N_HID,
  parameter int AW    = NN_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] pix_addr,
  output logic [AW-1:0] wt_addr,
  output logic [5:0]    l1_sel,
  output logic          mul_0,
  output logic          add_0,
  output logic          mul_1,
  output logic          add_1,
  output logic          l1_en,
  output logic          out_en,
  output logic          clr,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] L1_LAST = AW'(N_PIX - 1);
  localparam logic [AW-1:0] L2_LAST = AW'(N_HID - 1);
  localparam logic [AW-1:0] L2_BASE = AW'(l2_base(N_PIX));

  nn_state_t     state, state_next;
  logic [AW-1:0] step;
  logic [AW-1:0] step_last;
  logic          step_tc;
  logic          step_en;
  logic          step_clear;
  logic          l1_stb_q;
  logic          l2_stb_q;
  logic [5:0]    sel_q;

  // One counter serves both layers; it wraps to 0 on the L1 terminal count,
  // so L2 starts at j=0 without an extra clear cycle.
  nn_step_counter #(.AW(AW)) u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (step_clear),
    .en    (step_en),
    .last  (step_last),
    .count (step),
    .tc    (step_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      l1_stb_q <= 1'b0;
      l2_stb_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      state    <= state_next;
      l1_stb_q <= (state == ST_L1);
      l2_stb_q <= (state == ST_L2);
      sel_q    <= (state == ST_L2) ? step[5:0] : 6'd0;
    end
  end

  always_comb begin
    state_next = state;
    step_en    = 1'b0;
    step_clear = 1'b0;
    step_last  = L1_LAST;
    pix_addr   = '0;
    wt_addr    = '0;
    clr        = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        step_clear = 1'b1;
        if (start) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        step_clear = 1'b1;
        clr        = 1'b1;
        state_next = ST_L1;
      end
      ST_L1: begin
        step_en  = 1'b1;
        pix_addr = step;
        wt_addr  = step;
        if (step_tc) state_next = ST_L2;
      end
      ST_L2: begin
        step_en   = 1'b1;
        step_last = L2_LAST;
        wt_addr   = L2_BASE + step;
        if (step_tc) state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy   = (state != ST_IDLE);
  assign mul_0  = l1_stb_q;
  assign add_0  = l1_stb_q;
  assign l1_en  = l1_stb_q;
  assign mul_1  = l2_stb_q;
  assign add_1  = l2_stb_q;
  assign out_en = l2_stb_q;
  assign l1_sel = sel_q;

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed bench for nn_sequencer with a behavioural MUL/ADD datapath scoreboard.
module tb_nn_sequencer;

  localparam int N_PIX = 784;
  localparam int N_HID = 56;
  localparam int AW    = 10;
  localparam int N_OUT = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] pix_addr;
  logic [AW-1:0] wt_addr;
  logic [5:0]    l1_sel;
  logic          mul_0, add_0, mul_1, add_1, l1_en, out_en, clr, busy, done;

  nn_sequencer #(.N_PIX(N_PIX), .N_HID(N_HID), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pix_addr (pix_addr),
    .wt_addr  (wt_addr),
    .l1_sel   (l1_sel),
    .mul_0    (mul_0),
    .add_0    (add_0),
    .mul_1    (mul_1),
    .add_1    (add_1),
    .l1_en    (l1_en),
    .out_en   (out_en),
    .clr      (clr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_count = 0;
  int t0 = 0;

  int cnt_l1, cnt_l2, first_l1, last_l1, first_l2, last_l2;
  int done_cnt, done_cyc, done2_cyc, clr_cyc, clr2_cyc;
  int seq_err = 0;
  int idle_err = 0;
  int prev_wt = 0;
  int prev_pix = 0;

  int     pix_mem [N_PIX];
  int     wt_mem  [N_PIX+N_HID][N_HID];
  int     pix_q;
  int     wt_q    [N_HID];
  longint hid_model [N_HID];
  longint out_model [N_OUT];
  longint hid_ref   [N_HID];
  longint out_ref   [N_OUT];

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  always @(posedge clk) edge_count++;

  // Behavioural datapath: registered memories feed accumulators gated by DUT strobes.
  always @(posedge clk) begin
    if (clr) begin
      for (int n = 0; n < N_HID; n++) hid_model[n] = 0;
      for (int o = 0; o < N_OUT; o++) out_model[o] = 0;
    end else begin
      if (mul_0 && add_0 && l1_en)
        for (int n = 0; n < N_HID; n++) hid_model[n] += longint'(pix_q) * wt_q[n];
      if (mul_1 && add_1 && out_en)
        for (int o = 0; o < N_OUT; o++) out_model[o] += hid_model[l1_sel] * wt_q[o];
    end
    pix_q = pix_mem[pix_addr];
    for (int n = 0; n < N_HID; n++) wt_q[n] = wt_mem[wt_addr][n];
  end

  always @(negedge clk) begin
    int cyc;
    cyc = edge_count - t0;
    if (mul_0) begin
      if (cnt_l1 == 0) first_l1 = cyc;
      last_l1 = cyc;
      if (prev_wt != cnt_l1 % N_PIX || prev_pix != cnt_l1 % N_PIX) seq_err++;
      cnt_l1++;
    end
    if (mul_1) begin
      if (cnt_l2 == 0) first_l2 = cyc;
      last_l2 = cyc;
      if (prev_wt != N_PIX + cnt_l2 % N_HID) seq_err++;
      if (int'(l1_sel) != cnt_l2 % N_HID) seq_err++;
      cnt_l2++;
    end
    if (mul_0 !== add_0 || mul_0 !== l1_en) seq_err++;
    if (mul_1 !== add_1 || mul_1 !== out_en) seq_err++;
    if (mul_0 && mul_1) seq_err++;
    if (busy === 1'b0 && (pix_addr != 0 || wt_addr != 0 || mul_0 || mul_1 || clr || done))
      idle_err++;
    if (clr) begin
      if (clr_cyc < 0) clr_cyc = cyc;
      else if (done_cnt > 0 && clr2_cyc < 0) clr2_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) done_cyc = cyc;
      else if (done_cnt == 2) done2_cyc = cyc;
    end
    prev_wt  = int'(wt_addr);
    prev_pix = int'(pix_addr);
  end

  task automatic clearMon();
    cnt_l1 = 0; cnt_l2 = 0;
    first_l1 = -1; last_l1 = -1; first_l2 = -1; last_l2 = -1;
    done_cnt = 0; done_cyc = -1; done2_cyc = -1; clr_cyc = -1; clr2_cyc = -1;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    clearMon();
    start = 1'b1;
    t0 = edge_count;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for n_done done pulses, optionally pulsing start or asserting reset at a cycle.
  task automatic runWait(input int n_done, input int pulse_at, input int rst_at, input int limit);
    int c;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      c = edge_count - t0;
      if (c == pulse_at) start = 1'b1;
      else if (c == pulse_at + 1) start = 1'b0;
      if (c == rst_at) rst_n = 1'b0;
      if (c == rst_at + 1) begin
        checkOutput("busy after reset", longint'(busy), 0);
        checkOutput("done during reset", longint'(done_cnt), 0);
        rst_n = 1'b1;
        return;
      end
      if (done_cnt >= n_done) return;
    end
    checkOutput("done timeout", longint'(done_cnt), longint'(n_done));
  endtask

  task automatic checkFullRun(input string tag);
    checkOutput({tag, " clr cycle"}, clr_cyc, 1);
    checkOutput({tag, " l1 count"}, cnt_l1, N_PIX);
    checkOutput({tag, " l1 first"}, first_l1, 3);
    checkOutput({tag, " l1 last"}, last_l1, 786);
    checkOutput({tag, " l2 count"}, cnt_l2, N_HID);
    checkOutput({tag, " l2 first"}, first_l2, 787);
    checkOutput({tag, " l2 last"}, last_l2, 842);
    checkOutput({tag, " done cycle"}, done_cyc, 843);
  endtask

  initial begin
    clearMon();
    for (int k = 0; k < N_PIX; k++) pix_mem[k] = int'($urandom_range(0, 15));
    for (int r = 0; r < N_PIX + N_HID; r++)
      for (int n = 0; n < N_HID; n++) wt_mem[r][n] = int'($urandom_range(0, 6)) - 3;
    for (int n = 0; n < N_HID; n++) begin
      hid_ref[n] = 0;
      for (int k = 0; k < N_PIX; k++) hid_ref[n] += longint'(pix_mem[k]) * wt_mem[k][n];
    end
    for (int o = 0; o < N_OUT; o++) begin
      out_ref[o] = 0;
      for (int j = 0; j < N_HID; j++) out_ref[o] += hid_ref[j] * wt_mem[N_PIX + j][o];
    end

    repeat (2) @(negedge clk);
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset done", longint'(done), 0);
    checkOutput("reset clr", longint'(clr), 0);
    checkOutput("reset strobes", longint'({mul_0, add_0, mul_1, add_1, l1_en, out_en}), 0);
    checkOutput("reset pix_addr", longint'(pix_addr), 0);
    checkOutput("reset wt_addr", longint'(wt_addr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus();
    runWait(1, -1, -1, 1000);
    checkFullRun("run1");
    @(negedge clk);
    checkOutput("run1 idle busy", longint'(busy), 0);
    for (int o = 0; o < N_OUT; o++) checkOutput($sformatf("output_reg[%0d]", o), out_model[o], out_ref[o]);

    applyStimulus();
    runWait(1, 100, -1, 1000);
    repeat (5) @(negedge clk);
    checkFullRun("ignore start");
    checkOutput("ignore start done count", done_cnt, 1);
    checkOutput("ignore start busy", longint'(busy), 0);

    applyStimulus();
    runWait(1, -1, 400, 1000);
    repeat (10) @(negedge clk);
    checkOutput("abort done count", done_cnt, 0);
    checkOutput("abort busy", longint'(busy), 0);
    applyStimulus();
    runWait(1, -1, -1, 1000);
    checkFullRun("rerun");

    @(negedge clk);
    clearMon();
    start = 1'b1;
    t0 = edge_count;
    runWait(2, -1, -1, 2000);
    checkOutput("held first done", done_cyc, 843);
    checkOutput("held clr after done", clr2_cyc, 845);
    checkOutput("held second done", done2_cyc, 1687);
    checkOutput("held l1 count", cnt_l1, 2 * N_PIX);
    checkOutput("held l2 count", cnt_l2, 2 * N_HID);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("held final busy", longint'(busy), 0);

    checkOutput("sequence errors", seq_err, 0);
    checkOutput("idle errors", idle_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
